// File: rtl/hpi_txn_arbiter.sv
// Round-robin arbiter that runs one requester's read/write at a time on the HPI bus with programmable setup/strobe/hold phases.
// Accept pulse follows a sampled request by one cycle; completion pulses 1+SETUP+STROBE+HOLD cycles after accept.
module hpi_txn_arbiter #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_write,
  input  logic [1:0]  req0_addr,
  input  logic [15:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_write,
  input  logic [1:0]  req1_addr,
  input  logic [15:0] req1_wdata,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [15:0] rsp_rdata,
  output logic [1:0]  hpi_addr,
  output logic [15:0] hpi_data_out,
  input  logic [15:0] hpi_data_in,
  output logic        hpi_r,
  output logic        hpi_w,
  output logic        hpi_cs,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        ready0_q, ready0_d, ready1_q, ready1_d;
  logic        rsp0_q, rsp0_d, rsp1_q, rsp1_d;
  logic [15:0] rdata_q, rdata_d;
  logic        cs_q, cs_d, r_q, r_d, w_q, w_d, busy_q, busy_d;
  logic [1:0]  haddr_q, haddr_d;
  logic [15:0] hdata_q, hdata_d;

  logic phase_done, grant_en, pick1, bus_on;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_done = (cnt_q == 4'd0);
    case (state_q)
      ST_IDLE: begin
        // The accept cycle itself is an IDLE cycle; the bus phases start right after it.
        if (ready0_q || ready1_q) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (phase_done) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_STROBE: begin
        if (phase_done) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        if (phase_done) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase

    // On a tie the requester that was not granted last wins.
    pick1    = req1_valid && (!req0_valid || !last_q);
    grant_en = (state_d == ST_IDLE) && (req0_valid || req1_valid);
    ready0_d = grant_en && !pick1;
    ready1_d = grant_en && pick1;
    last_d   = grant_en ? pick1 : last_q;
    gnt_d    = grant_en ? pick1 : gnt_q;
    wr_d     = grant_en ? (pick1 ? req1_write : req0_write) : wr_q;
    addr_d   = grant_en ? (pick1 ? req1_addr  : req0_addr)  : addr_q;
    wdata_d  = grant_en ? (pick1 ? req1_wdata : req0_wdata) : wdata_q;

    rsp0_d  = (state_q == ST_HOLD) && phase_done && !gnt_q;
    rsp1_d  = (state_q == ST_HOLD) && phase_done && gnt_q;
    rdata_d = ((state_q == ST_STROBE) && phase_done && !wr_q) ? hpi_data_in : rdata_q;

    bus_on  = (state_d != ST_IDLE);
    busy_d  = bus_on;
    cs_d    = !bus_on;
    r_d     = !((state_d == ST_STROBE) && !wr_q);
    w_d     = !((state_d == ST_STROBE) && wr_q);
    haddr_d = bus_on ? addr_q : 2'd0;
    hdata_d = (bus_on && wr_q) ? wdata_q : 16'd0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 2'd0;
      wdata_q  <= 16'd0;
      ready0_q <= 1'b0;
      ready1_q <= 1'b0;
      rsp0_q   <= 1'b0;
      rsp1_q   <= 1'b0;
      rdata_q  <= 16'd0;
      cs_q     <= 1'b1;
      r_q      <= 1'b1;
      w_q      <= 1'b1;
      busy_q   <= 1'b0;
      haddr_q  <= 2'd0;
      hdata_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ready0_q <= ready0_d;
      ready1_q <= ready1_d;
      rsp0_q   <= rsp0_d;
      rsp1_q   <= rsp1_d;
      rdata_q  <= rdata_d;
      cs_q     <= cs_d;
      r_q      <= r_d;
      w_q      <= w_d;
      busy_q   <= busy_d;
      haddr_q  <= haddr_d;
      hdata_q  <= hdata_d;
    end
  end

  assign req0_ready   = ready0_q;
  assign req1_ready   = ready1_q;
  assign rsp0_valid   = rsp0_q;
  assign rsp1_valid   = rsp1_q;
  assign rsp_rdata    = rdata_q;
  assign hpi_addr     = haddr_q;
  assign hpi_data_out = hdata_q;
  assign hpi_r        = r_q;
  assign hpi_w        = w_q;
  assign hpi_cs       = cs_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_hpi_txn_arbiter.sv
// Directed bench for hpi_txn_arbiter: default-timing instance plus a SETUP=2/STROBE=4/HOLD=3 instance.
module tb_hpi_txn_arbiter;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset;
  logic        req0_valid, req1_valid, req0_write, req1_write;
  logic [1:0]  req0_addr, req1_addr;
  logic [15:0] req0_wdata, req1_wdata, hpi_data_in;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [15:0] rsp_rdata, hpi_data_out;
  logic [1:0]  hpi_addr;
  logic        hpi_r, hpi_w, hpi_cs, busy;

  logic        b_req0_valid, b_req0_write, b_req1_valid, b_req1_write;
  logic [1:0]  b_req0_addr, b_req1_addr;
  logic [15:0] b_req0_wdata, b_req1_wdata, b_hpi_data_in;
  logic        b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid;
  logic [15:0] b_rsp_rdata, b_hpi_data_out;
  logic [1:0]  b_hpi_addr;
  logic        b_hpi_r, b_hpi_w, b_hpi_cs, b_busy;

  hpi_txn_arbiter dut_a (
    .Clk(Clk), .Reset(Reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rdata(rsp_rdata),
    .hpi_addr(hpi_addr), .hpi_data_out(hpi_data_out), .hpi_data_in(hpi_data_in),
    .hpi_r(hpi_r), .hpi_w(hpi_w), .hpi_cs(hpi_cs), .busy(busy)
  );

  hpi_txn_arbiter #(.SETUP_CYC(2), .STROBE_CYC(4), .HOLD_CYC(3)) dut_b (
    .Clk(Clk), .Reset(Reset),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_write(b_req0_write),
    .req0_addr(b_req0_addr), .req0_wdata(b_req0_wdata),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_write(b_req1_write),
    .req1_addr(b_req1_addr), .req1_wdata(b_req1_wdata),
    .rsp0_valid(b_rsp0_valid), .rsp1_valid(b_rsp1_valid), .rsp_rdata(b_rsp_rdata),
    .hpi_addr(b_hpi_addr), .hpi_data_out(b_hpi_data_out), .hpi_data_in(b_hpi_data_in),
    .hpi_r(b_hpi_r), .hpi_w(b_hpi_w), .hpi_cs(b_hpi_cs), .busy(b_busy)
  );

  int n_chk = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus and accept invariants on both instances, every cycle once out of reset.
  always @(negedge Clk) begin
    if (mon_en) begin
      chk("inv_a", 32'({(!hpi_r || !hpi_w) && hpi_cs, !hpi_r && !hpi_w}), 32'd0);
      chk("rdy_a", 32'({req0_ready && req1_ready, (req0_ready || req1_ready) && busy}), 32'd0);
      chk("inv_b", 32'({(!b_hpi_r || !b_hpi_w) && b_hpi_cs, !b_hpi_r && !b_hpi_w}), 32'd0);
    end
  end

  task automatic txn_a(input bit rq, input bit wr, input logic [1:0] ad, input logic [15:0] wd,
                       output int rdy_n, output int cs_n, output int r_n, output int w_n,
                       output int lat, output int other, output logic [1:0] a_seen,
                       output logic [15:0] d_seen);
    int rdy_at;
    bit done;
    rdy_n = 0; cs_n = 0; r_n = 0; w_n = 0; lat = -1; other = 0;
    a_seen = 2'd0; d_seen = 16'd0; rdy_at = -1; done = 1'b0;
    if (!rq) begin
      req0_valid = 1'b1; req0_write = wr; req0_addr = ad; req0_wdata = wd;
    end else begin
      req1_valid = 1'b1; req1_write = wr; req1_addr = ad; req1_wdata = wd;
    end
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge Clk);
      if (rq ? req1_ready : req0_ready) begin
        rdy_n++;
        if (rdy_at < 0) rdy_at = k;
        // Scrambled fields after accept must not reach the bus.
        if (!rq) begin
          req0_valid = 1'b0; req0_write = ~wr; req0_addr = ~ad; req0_wdata = ~wd;
        end else begin
          req1_valid = 1'b0; req1_write = ~wr; req1_addr = ~ad; req1_wdata = ~wd;
        end
      end
      if (rq ? (req0_ready || rsp0_valid) : (req1_ready || rsp1_valid)) other++;
      if (!hpi_cs) cs_n++;
      if (!hpi_r) begin r_n++; a_seen = hpi_addr; end
      if (!hpi_w) begin w_n++; a_seen = hpi_addr; d_seen = hpi_data_out; end
      if ((rq ? rsp1_valid : rsp0_valid) && rdy_at >= 0) begin
        lat = k - rdy_at;
        done = 1'b1;
      end
    end
  endtask

  int rdy_n, cs_n, r_n, w_n, lat, other, ng, nr, rdy_at, r0_cnt, rsp_cnt;
  logic [1:0]  a_seen;
  logic [15:0] d_seen;
  int g_id[4], g_cyc[4], r_id[4], r_cyc[4];
  bit found;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
    hpi_data_in = 16'hBEEF;
    b_req0_valid = 0; b_req0_write = 0; b_req0_addr = 0; b_req0_wdata = 0;
    b_req1_valid = 0; b_req1_write = 0; b_req1_addr = 0; b_req1_wdata = 0;
    b_hpi_data_in = 16'h0C0F;
    repeat (3) @(negedge Clk);
    chk("rst_strobes", 32'({hpi_cs, hpi_r, hpi_w}), 32'h7);
    chk("rst_addr", 32'(hpi_addr), 32'd0);
    chk("rst_dout", 32'(hpi_data_out), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_flags", 32'({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid}), 32'd0);
    chk("rst_b_strobes", 32'({b_hpi_cs, b_hpi_r, b_hpi_w, b_busy}), 32'hE);
    Reset = 1'b0;
    mon_en = 1'b1;

    // Single read from requester 0.
    txn_a(1'b0, 1'b0, 2'd2, 16'h0000, rdy_n, cs_n, r_n, w_n, lat, other, a_seen, d_seen);
    chk("rd_ready_cnt", rdy_n, 1);
    chk("rd_cs_low", cs_n, 5);
    chk("rd_r_low", r_n, 3);
    chk("rd_w_low", w_n, 0);
    chk("rd_latency", lat, 6);
    chk("rd_addr", 32'(a_seen), 32'd2);
    chk("rd_other", other, 0);
    chk("rd_rdata", 32'(rsp_rdata), 32'hBEEF);

    // Single write from requester 1; bus data-in changes must not reach rsp_rdata.
    hpi_data_in = 16'h5555;
    txn_a(1'b1, 1'b1, 2'd1, 16'h1234, rdy_n, cs_n, r_n, w_n, lat, other, a_seen, d_seen);
    chk("wr_ready_cnt", rdy_n, 1);
    chk("wr_w_low", w_n, 3);
    chk("wr_r_low", r_n, 0);
    chk("wr_cs_low", cs_n, 5);
    chk("wr_data", 32'(d_seen), 32'h1234);
    chk("wr_addr", 32'(a_seen), 32'd1);
    chk("wr_latency", lat, 6);
    chk("wr_other", other, 0);
    chk("wr_rdata_kept", 32'(rsp_rdata), 32'hBEEF);
    @(negedge Clk);
    chk("idle_bus", 32'({hpi_addr, hpi_data_out}), 32'd0);

    // Continuous contention after reset: strict alternation, back-to-back on rsp cycle.
    hpi_data_in = 16'hBEEF;
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    req0_valid = 1; req0_write = 0; req0_addr = 2'd0;
    req1_valid = 1; req1_write = 0; req1_addr = 2'd3;
    ng = 0; nr = 0;
    for (int k = 1; k <= 40 && ng < 4; k++) begin
      @(negedge Clk);
      if (rsp0_valid || rsp1_valid) begin
        if (nr < 4) begin r_id[nr] = rsp1_valid ? 1 : 0; r_cyc[nr] = k; end
        nr++;
      end
      if (req0_ready || req1_ready) begin
        g_id[ng] = req1_ready ? 1 : 0; g_cyc[ng] = k;
        ng++;
      end
    end
    req0_valid = 0; req1_valid = 0;
    chk("rr_grants", ng, 4);
    chk("rr_rsps", nr, 3);
    for (int i = 0; i < 4; i++) chk("rr_order", g_id[i], i % 2);
    for (int i = 0; i < 3; i++) begin
      chk("rr_spacing", g_cyc[i+1] - g_cyc[i], 6);
      chk("rr_b2b", r_cyc[i], g_cyc[i+1]);
      chk("rr_rsp_id", r_id[i], g_id[i]);
    end
    repeat (8) @(negedge Clk);

    // Reset pulsed during a read strobe aborts without a response.
    chk("pre_abort_rdata", 32'(rsp_rdata), 32'hBEEF);
    req0_valid = 1; req0_write = 0; req0_addr = 2'd2;
    found = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      @(negedge Clk);
      if (req0_ready) req0_valid = 0;
      if (!hpi_r) found = 1'b1;
    end
    chk("abort_strobe_seen", 32'(found), 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("abort_bus", 32'({hpi_cs, hpi_r, busy}), 32'h6);
    chk("abort_rdata", 32'(rsp_rdata), 32'd0);
    rsp_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      if (rsp0_valid || rsp1_valid) rsp_cnt++;
    end
    chk("abort_no_rsp", rsp_cnt, 0);

    // Short req0 pulse while requester 1 owns the bus is dropped.
    req1_valid = 1; req1_write = 1; req1_addr = 2'd3; req1_wdata = 16'hA5A5;
    rdy_at = -1; r0_cnt = 0; lat = -1; found = 1'b0;
    for (int k = 1; k <= 30 && !found; k++) begin
      @(negedge Clk);
      if (req1_ready) begin req1_valid = 0; rdy_at = k; end
      if (req0_ready || rsp0_valid) r0_cnt++;
      if (rdy_at > 0 && k == rdy_at + 2) begin req0_valid = 1; req0_write = 0; req0_addr = 2'd0; end
      if (rdy_at > 0 && k == rdy_at + 3) req0_valid = 0;
      if (rsp1_valid) begin lat = k - rdy_at; found = 1'b1; chk("drop_busy_rsp", 32'(busy), 32'd0); end
    end
    chk("drop_req0_ignored", r0_cnt, 0);
    chk("drop_rsp1_latency", lat, 6);
    @(negedge Clk);
    chk("drop_idle", 32'({busy, req0_ready, rsp0_valid}), 32'd0);

    // Stretched timing instance.
    b_req0_valid = 1; b_req0_write = 0; b_req0_addr = 2'd2;
    rdy_at = -1; cs_n = 0; r_n = 0; w_n = 0; lat = -1; found = 1'b0;
    for (int k = 1; k <= 40 && !found; k++) begin
      @(negedge Clk);
      if (b_req0_ready) begin b_req0_valid = 0; rdy_at = k; end
      if (!b_hpi_cs) cs_n++;
      if (!b_hpi_r) r_n++;
      if (!b_hpi_w) w_n++;
      if (b_rsp0_valid && rdy_at > 0) begin lat = k - rdy_at; found = 1'b1; end
    end
    chk("b_cs_low", cs_n, 9);
    chk("b_r_low", r_n, 4);
    chk("b_w_low", w_n, 0);
    chk("b_latency", lat, 10);
    chk("b_rdata", 32'(b_rsp_rdata), 32'h0C0F);
    repeat (2) @(negedge Clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
